fp_div_seq: RTL and testbench

Sequential signed fixed-point divider, the inverse of the `fp_mult` datapath. Given a signed integer product `dividend` and a signed Q(n-f).f fraction `divisor`, it recovers `quotient = (dividend · 2^f) / divisor`, so that `fp_mult(quotient, divisor) ≈ dividend`. It uses a start/done handshake and a multi-cycle restoring division, and sits beside `fp_mult` in the arithmetic unit.

---
 rtl/fp_div_seq.sv | 188 ++++++++++++++++++
 tb/tb_fp_div_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_seq.sv
// Signed fixed-point divider: quotient = (dividend * 2^f) / divisor, saturating, restoring radix-2.
// Latency: n+f+1 edges from the start edge to done (1 edge when the divisor is zero).
// No backpressure: start is only accepted in IDLE; start while busy is dropped, never queued.
module fp_div_seq #(
    parameter int n = 8,
    parameter int f = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [n-1:0] dividend,
    input  logic [n-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] quotient,
    output logic         overflow,
    output logic         div_by_zero
);
    // Numerator / magnitude-quotient width and iteration counter width.
    localparam int W  = n + f;
    localparam int CW = $clog2(W + 1);

    // Saturation codes and the magnitude limits they are compared against.
    localparam logic [n-1:0]  QMAX    = {1'b0, {(n-1){1'b1}}};
    localparam logic [n-1:0]  QMIN    = {1'b1, {(n-1){1'b0}}};
    localparam logic [W-1:0]  POS_LIM = W'(QMAX);
    localparam logic [W-1:0]  NEG_LIM = W'(QMIN);
    localparam logic [n-1:0]  ONE_N   = n'(1);
    localparam logic [W-1:0]  ONE_W   = W'(1);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW-1:0] LAST_C  = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Operation context captured at the start edge.
    logic          sign_dvd;
    logic          sign_dvs;
    logic          dbz_sel;
    logic [W-1:0]  num;
    logic [n-1:0]  dvs_mag;

    // Restoring-division working state.
    logic [n:0]    rem;
    logic [W-1:0]  qmag;
    logic [CW-1:0] cnt;

    // Combinational helpers.
    logic [n-1:0]  dvd_abs;
    logic [n-1:0]  dvs_abs;
    logic          divisor_zero;
    logic [n:0]    rem_sh;
    logic [n:0]    rem_sub;
    logic          q_bit;
    logic          last_step;
    logic          res_neg;
    logic [W-1:0]  qmag_neg;

    // |-2^(n-1)| wraps back to 2^(n-1), which is exactly right when read as unsigned.
    assign dvd_abs      = dividend[n-1] ? (~dividend + ONE_N) : dividend;
    assign dvs_abs      = divisor[n-1]  ? (~divisor  + ONE_N) : divisor;
    assign divisor_zero = (divisor == '0);

    // One restoring step: bring in the next numerator bit, trial-subtract the divisor.
    // rem[n] is always 0 after a restoring step, but folding it into q_bit keeps the step exact.
    assign rem_sh    = {rem[n-1:0], num[W-1]};
    assign q_bit     = rem[n] | (rem_sh >= {1'b0, dvs_mag});
    assign rem_sub   = rem_sh - {1'b0, dvs_mag};
    assign last_step = (cnt == LAST_C);

    assign res_neg  = sign_dvd ^ sign_dvs;
    assign qmag_neg = ~qmag + ONE_W;

    assign busy = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: zero divisor skips the iterations entirely.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = divisor_zero ? FIX : CALC;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture at start and one quotient bit per CALC cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            sign_dvd <= 1'b0;
            sign_dvs <= 1'b0;
            dbz_sel  <= 1'b0;
            num      <= '0;
            dvs_mag  <= '0;
            rem      <= '0;
            qmag     <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_dvd <= dividend[n-1];
                        sign_dvs <= divisor[n-1];
                        dbz_sel  <= divisor_zero;
                        num      <= {dvd_abs, {f{1'b0}}};
                        dvs_mag  <= dvs_abs;
                        rem      <= '0;
                        qmag     <= '0;
                        cnt      <= '0;
                    end
                end
                CALC: begin
                    rem  <= q_bit ? rem_sub : rem_sh;
                    qmag <= {qmag[W-2:0], q_bit};
                    num  <= {num[W-2:0], 1'b0};
                    cnt  <= cnt + ONE_C;
                end
                default: begin
                end
            endcase
        end
    end

    // Result formatting: sign, saturation and divide-by-zero, registered in FIX with the done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            done        <= 1'b0;
            quotient    <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= (state == FIX);
            if (state == FIX) begin
                if (dbz_sel) begin
                    quotient    <= sign_dvd ? QMIN : QMAX;
                    overflow    <= 1'b0;
                    div_by_zero <= 1'b1;
                end else begin
                    div_by_zero <= 1'b0;
                    if (qmag == '0) begin
                        quotient <= '0;
                        overflow <= 1'b0;
                    end else if (!res_neg && (qmag > POS_LIM)) begin
                        quotient <= QMAX;
                        overflow <= 1'b1;
                    end else if (res_neg && (qmag > NEG_LIM)) begin
                        quotient <= QMIN;
                        overflow <= 1'b1;
                    end else if (res_neg) begin
                        quotient <= qmag_neg[n-1:0];
                        overflow <= 1'b0;
                    end else begin
                        quotient <= qmag[n-1:0];
                        overflow <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_div_seq.sv
// Bench for fp_div_seq: directed cases, handshake/reset cases and random round-trips.
// Expected results come from an integer-arithmetic reference model pushed into a scoreboard queue.
// A monitor pops and compares on every done pulse, independent of the stimulus process.
module tb_fp_div_seq;
    localparam int N = 8;
    localparam int F = 7;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic         overflow;
    logic         div_by_zero;

    fp_div_seq #(.n(N), .f(F)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] q;
        logic         ovf;
        logic         dbz;
        int           e0;
        int           lat;
        bit           rt;
        int           a;
        int           b;
        string        name;
    } exp_t;

    exp_t         exp_q[$];
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           done_cnt = 0;
    logic [N-1:0] held_q = '0;
    logic         held_o = 1'b0;
    logic         held_z = 1'b0;

    // Interpret an N-bit word as a signed integer.
    function automatic int sx(logic [N-1:0] x);
        return x[N-1] ? (int'(x) - (1 << N)) : int'(x);
    endfunction

    // Reference: exact integer division truncating toward zero, then saturate.
    function automatic exp_t model(int dvd, int dvs);
        exp_t e;
        int   qi;
        e.ovf = 1'b0; e.dbz = 1'b0; e.e0 = 0; e.rt = 1'b0; e.a = 0; e.b = dvs; e.name = "";
        if (dvs == 0) begin
            e.dbz = 1'b1;
            e.lat = 1;
            qi = (dvd >= 0) ? ((1 << (N-1)) - 1) : -(1 << (N-1));
        end else begin
            e.lat = N + F + 1;
            qi = (dvd * (1 << F)) / dvs;
            if (qi > (1 << (N-1)) - 1) begin
                qi = (1 << (N-1)) - 1;
                e.ovf = 1'b1;
            end else if (qi < -(1 << (N-1))) begin
                qi = -(1 << (N-1));
                e.ovf = 1'b1;
            end
        end
        e.q = N'(qi);
        return e;
    endfunction

    task automatic check(string nm, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Monitor: compare every done pulse against the scoreboard; outputs must hold in between.
    always @(posedge clk) begin : mon
        exp_t e;
        int   d;
        int   ab;
        #1;
        cyc++;
        if (reset) begin
            held_q = '0; held_o = 1'b0; held_z = 1'b0;
        end else if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check({e.name, " quotient"}, int'(quotient), int'(e.q));
                check({e.name, " overflow"}, int'(overflow), int'(e.ovf));
                check({e.name, " div_by_zero"}, int'(div_by_zero), int'(e.dbz));
                check({e.name, " latency"}, cyc - e.e0, e.lat);
                check({e.name, " busy_in_done"}, int'(busy), 0);
                if (e.rt) begin
                    d  = sx(quotient) - e.a;
                    d  = (d < 0) ? -d : d;
                    ab = (e.b < 0) ? -e.b : e.b;
                    check({e.name, " roundtrip_err_ok"}, int'(d * ab <= (1 << F) + ab), 1);
                end
            end
            held_q = quotient; held_o = overflow; held_z = div_by_zero;
        end else begin
            check("hold", int'({quotient, overflow, div_by_zero}), int'({held_q, held_o, held_z}));
        end
    end

    // Drive one start (caller is at a negedge); expected result goes on the scoreboard.
    task automatic issue(logic [N-1:0] dvd, logic [N-1:0] dvs, string nm, bit rt, int a);
        exp_t e;
        e      = model(sx(dvd), sx(dvs));
        e.name = nm;
        e.e0   = cyc + 1;
        e.rt   = rt;
        e.a    = a;
        exp_q.push_back(e);
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = N'($urandom);
        divisor  = N'($urandom);
    endtask

    // Wait (bounded) for done; optionally pulse a stray start after pulse_at cycles.
    task automatic wait_done(int pulse_at);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (i == pulse_at) begin
                start    = 1'b1;
                dividend = N'($urandom);
                divisor  = N'($urandom_range(1, 255));
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done) got = 1'b1;
        end
        start = 1'b0;
        if (!got) begin
            check("timeout_waiting_done", 0, 1);
            exp_q.delete();
        end
    endtask

    task automatic op(logic [N-1:0] dvd, logic [N-1:0] dvs, string nm, int gap);
        repeat (gap) @(negedge clk);
        issue(dvd, dvs, nm, 1'b0, 0);
        wait_done(-1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin : stim
        int a, b, p, tries, dc;
        reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        check("rst quotient", int'(quotient), 0);
        check("rst flags", int'({overflow, div_by_zero, done, busy}), 0);
        reset = 1'b0;

        op(8'h20, 8'h40, "32/0.5", 2);
        op(8'hE8, 8'h60, "-24/0.75", 1);
        op(8'd10, 8'h30, "10/0.375", 0);
        op(8'hF6, 8'h30, "-10/0.375", 3);
        op(8'd100, 8'h20, "100/0.25", 0);
        op(8'h80, 8'h80, "-128/-1", 1);
        op(8'd100, 8'h80, "100/-1", 0);
        op(8'hFB, 8'h00, "-5/0", 2);
        op(8'd5, 8'h00, "5/0", 0);
        op(8'h00, 8'h55, "0/x", 0);

        // stray start in the middle of CALC must not disturb the result
        @(negedge clk);
        issue(8'h20, 8'h40, "stray_start", 1'b0, 0);
        wait_done(5);

        // back-to-back: each start lands in the previous done cycle
        op(8'd37, 8'h50, "b2b_1", 0);
        op(8'hC3, 8'hB0, "b2b_2", 0);
        op(8'd90, 8'h70, "b2b_3", 0);

        // reset at E8 while an operation is in flight
        dc = done_cnt;
        @(negedge clk);
        dividend = 8'd50; divisor = 8'h40; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("reset_mid quotient", int'(quotient), 0);
        check("reset_mid flags", int'({overflow, div_by_zero, done, busy}), 0);
        repeat (25) @(negedge clk);
        check("reset_mid no_done", done_cnt, dc);

        // round-trip: dividend = fp_mult(a, b), truncated product, no overflow
        for (int k = 0; k < 100; k++) begin
            tries = 0;
            do begin
                a = sx(N'($urandom));
                b = sx(N'($urandom_range(1, 255)));
                p = (a * b) >>> F;
                tries++;
            end while ((p > 127 || p < -128) && tries < 50);
            if (p > 127 || p < -128) begin
                a = 1; b = 64; p = 0;
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(N'(p), N'(b), "roundtrip", 1'b1, a);
            wait_done(-1);
        end

        // fully random operands, zero divisor included now and then
        for (int k = 0; k < 40; k++) begin
            op(N'($urandom), ($urandom_range(0, 7) == 0) ? 8'h00 : N'($urandom), "random",
               $urandom_range(0, 2));
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
